dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the Nova core's load/store port, the slave end of the CPU data bus. It accepts one request at a time over a valid/ready handshake and executes a word read or a byte-masked write against an internal word RAM. It returns the result on a separate valid/ready response channel after a fixed number of wait states. It also flags misaligned and out-of-range addresses so the core can trap on bad accesses.

## Interface
- `ADDR_W`, default 10: word-address width; RAM depth is 2^ADDR_W 32-bit words, so the byte range is 0 .. 2^(ADDR_W+2)-1.
- `LATENCY`, default 1: wait states between request accept and response, legal range 0..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  the core presents a request.
- `req_ready`  out  1  the responder can accept a request this cycle.
- `req_addr`  in  32  byte address.
- `req_we`  in  1  1 = write, 0 = read.
- `req_wstrb`  in  4  byte enables for writes; bit i selects `wdata[8i+7:8i]`.
- `req_wdata`  in  32  write data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  the core accepts the response.
- `resp_rdata`  out  32  read data; 0 for writes and errors.
- `resp_err`  out  1  the access was misaligned or out of range.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE**
  - `req_ready` = 1.
  - On a rising edge with `req_valid & req_ready` (the accept edge), latch addr, we, wstrb and wdata, and load the wait counter with LATENCY.
  - Next state is RESP if LATENCY = 0, otherwise WAIT.
- **WAIT**
  - `req_ready` = 0. The counter decrements once per cycle.
  - On the edge where the counter reaches 1, perform the access and go to RESP.
- **RESP**
  - `resp_valid` = 1 and `req_ready` = 0. `resp_rdata` and `resp_err` stay stable for as long as `resp_valid` is high.
  - On the edge with `resp_ready` = 1, return to IDLE.
- **Access (commit) edge**: the edge entering RESP. With LATENCY = 0 this is the accept edge.
  - Error condition: `err = (addr[1:0] != 0) | (addr[31:ADDR_W+2] != 0)`.
  - err = 1: RAM is untouched, `resp_rdata` = 0, `resp_err` = 1.
  - Read, no error: `resp_rdata` = RAM[`addr[ADDR_W+1:2]`], `resp_err` = 0.
  - Write, no error: each byte i with `wstrb[i]` = 1 is updated, other bytes are kept; `resp_rdata` = 0, `resp_err` = 0. A write with `wstrb` = 0 is legal: it changes nothing and still gets a response.
- Only one transaction is outstanding at a time. Requests arriving during WAIT or RESP are not accepted; the core must hold `req_valid` and its payload until `req_ready`.
- A read that follows a write to the same word returns the written data, because commits are ordered.
- RAM contents are not affected by reset. Words that have never been written read back as undefined.

## Timing
- Reset values: state = IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, counter = 0.
- Reset takes priority over every other event and aborts the transaction in flight:
  - a write whose commit edge coincides with reset, or comes later, is not performed;
  - a pending response is dropped.
- `resp_valid` rises LATENCY+1 cycles after the accept edge. LATENCY = 0 gives the response in the cycle right after accept.
- `req_ready` returns to 1 in the cycle after the response handshake edge. The minimum request period is therefore LATENCY+2 cycles.
- `resp_valid` is registered. `req_ready` is a pure function of the state; it never depends combinationally on `req_valid` or `resp_ready`.
- Back-pressure: `resp_ready` held at 0 keeps the FSM in RESP indefinitely with the outputs unchanged.

## Test plan
- Reset state and basic write: after reset, `req_ready` = 1 and `resp_valid` = 0. With LATENCY = 1, write 0xDEADBEEF to 0x10 with wstrb = 0xF, then read 0x10. Required: `resp_rdata` = 0xDEADBEEF, `err` = 0, and `resp_valid` arrives exactly 2 cycles after each accept.
- Byte strobes: write 0x11223344 to 0x20 with wstrb = 0xF, then write 0xAABBCCDD with wstrb = 0x5, then read. Required: 0x11BB33DD.
- Errors, with ADDR_W = 10:
  - read at 0x0000_0006 -> `err` = 1, `rdata` = 0;
  - write at 0x0000_1000 -> `err` = 1;
  - a later read of 0x0 -> its prior contents are unchanged.
- Back-pressure: hold `resp_ready` = 0 for 5 cycles in RESP. Required: `resp_valid` and `rdata` stay stable and `req_ready` stays 0; one cycle after `resp_ready` = 1, `req_ready` = 1.
- LATENCY sweep: with LATENCY = 0, a response arrives 1 cycle after accept; with LATENCY = 15, 16 cycles after accept. Back-to-back requests with `req_valid` held high are spaced LATENCY+2 cycles apart.
- Reset mid-write: with LATENCY = 3, write 0x55 to 0x40 and assert reset 2 cycles after accept. Required: FSM returns to IDLE with no response, and a subsequent read of 0x40 returns the previously written 0x12345678.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store bus between the Nova core (master) and the data-memory responder (slave).
// Request and response are independent valid/ready channels.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wstrb, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wstrb, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding word read or byte-masked write,
// answered after LATENCY wait states, with misalignment/range error flagging.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [3:0] LAT     = LATENCY[3:0];

  logic [1:0]  state;
  logic [3:0]  count;
  logic [31:0] lat_addr;
  logic        lat_we;
  logic [3:0]  lat_wstrb;
  logic [31:0] lat_wdata;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] ram [DEPTH];

  logic              accept;
  logic              commit;
  logic [31:0]       c_addr;
  logic              c_we;
  logic [3:0]        c_wstrb;
  logic [31:0]       c_wdata;
  logic              c_err;
  logic [ADDR_W-1:0] c_idx;

  assign accept = (state == ST_IDLE) && bus.req_valid;

  // With zero wait states the access happens on the accept edge, so it must
  // use the live request fields instead of the (not yet loaded) latches.
  always_comb begin
    if (state == ST_IDLE) begin
      c_addr  = bus.req_addr;
      c_we    = bus.req_we;
      c_wstrb = bus.req_wstrb;
      c_wdata = bus.req_wdata;
    end else begin
      c_addr  = lat_addr;
      c_we    = lat_we;
      c_wstrb = lat_wstrb;
      c_wdata = lat_wdata;
    end
  end

  assign commit = (LAT == 4'd0) ? accept : ((state == ST_WAIT) && (count == 4'd1));
  assign c_idx  = c_addr[ADDR_W+1:2];
  assign c_err  = (c_addr[1:0] != 2'b00) || ((c_addr >> (ADDR_W + 2)) != 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      count        <= 4'd0;
      lat_addr     <= 32'd0;
      lat_we       <= 1'b0;
      lat_wstrb    <= 4'd0;
      lat_wdata    <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_addr  <= bus.req_addr;
            lat_we    <= bus.req_we;
            lat_wstrb <= bus.req_wstrb;
            lat_wdata <= bus.req_wdata;
            if (LAT == 4'd0) begin
              state <= ST_RESP;
              count <= 4'd0;
            end else begin
              state <= ST_WAIT;
              count <= LAT;
            end
          end
        end
        ST_WAIT: begin
          if (count == 4'd1) begin
            state <= ST_RESP;
            count <= 4'd0;
          end else begin
            count <= count - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state        <= ST_IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (commit) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= c_err;
        resp_rdata_q <= (c_err || c_we) ? 32'd0 : ram[c_idx];
      end
    end
  end

  // RAM has no reset; a write landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (commit && !reset && c_we && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (c_wstrb[i]) ram[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four instances (LATENCY 1, 0, 15, 3)
// share a payload bus; a scoreboard queue holds the expected response per request.
module tb_dmem_responder;
  localparam int LATS [4] = '{1, 0, 15, 3};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid_v = 4'd0;
  logic [3:0]  resp_ready_v = 4'hF;
  logic [31:0] req_addr = 32'd0;
  logic        req_we = 1'b0;
  logic [3:0]  req_wstrb = 4'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_ready_v;
  logic [3:0]  resp_valid_v;
  logic [3:0]  err_v;
  logic [31:0] rdata_v [4];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder_if bus ();
    assign bus.req_valid  = req_valid_v[g];
    assign bus.req_addr   = req_addr;
    assign bus.req_we     = req_we;
    assign bus.req_wstrb  = req_wstrb;
    assign bus.req_wdata  = req_wdata;
    assign bus.resp_ready = resp_ready_v[g];
    assign req_ready_v[g]  = bus.req_ready;
    assign resp_valid_v[g] = bus.resp_valid;
    assign rdata_v[g]      = bus.resp_rdata;
    assign err_v[g]        = bus.resp_err;

    dmem_responder #(.ADDR_W(10), .LATENCY(LATS[g])) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance sel, then collect and score its response;
  // hold > 0 keeps resp_ready low for that many cycles once the response shows.
  task automatic apply_stimulus(input int sel, input logic we, input logic [31:0] addr,
                                input logic [3:0] wstrb, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int hold);
    exp_t e;
    int   t;
    int   acc;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wstrb = wstrb; req_wdata = wdata;
    req_valid_v[sel]  = 1'b1;
    resp_ready_v[sel] = (hold == 0);
    t = 0;
    while (req_ready_v[sel] !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    check_output("accept_in_time", 32'(t < 40), 32'd1);
    acc = cyc;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err, lat: LATS[sel]});
    @(posedge clk); #1;
    req_valid_v[sel] = 1'b0;
    @(negedge clk);
    t = 0;
    while (resp_valid_v[sel] !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    check_output("resp_in_time", 32'(t < 40), 32'd1);
    e = sb_q.pop_front();
    check_output("resp_rdata", rdata_v[sel], e.rdata);
    check_output("resp_err", 32'(err_v[sel]), 32'(e.err));
    check_output("resp_latency", 32'(cyc - acc), 32'(e.lat + 1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_output("bp_valid", 32'(resp_valid_v[sel]), 32'd1);
      check_output("bp_rdata", rdata_v[sel], e.rdata);
      check_output("bp_req_ready", 32'(req_ready_v[sel]), 32'd0);
    end
    resp_ready_v[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("ready_after_resp", 32'(req_ready_v[sel]), 32'd1);
    check_output("valid_after_resp", 32'(resp_valid_v[sel]), 32'd0);
  endtask

  // Hold req_valid high with empty-strobe writes and measure accept spacing.
  task automatic back_to_back(input int sel);
    int q [$];
    int lat;
    lat = LATS[sel];
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'd0; req_wstrb = 4'd0; req_wdata = 32'd0;
    resp_ready_v[sel] = 1'b1;
    req_valid_v[sel]  = 1'b1;
    for (int i = 0; i < 3 * (lat + 2) + 6; i++) begin
      if (req_ready_v[sel] === 1'b1) q.push_back(cyc);
      if (q.size() == 3) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
    req_valid_v[sel] = 1'b0;
    repeat (lat + 3) @(negedge clk);
    check_output("b2b_accepts", 32'(q.size()), 32'd3);
    if (q.size() == 3) begin
      check_output("b2b_spacing_0", 32'(q[1] - q[0]), 32'(lat + 2));
      check_output("b2b_spacing_1", 32'(q[2] - q[1]), 32'(lat + 2));
    end
    check_output("b2b_idle", 32'(req_ready_v[sel]), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      check_output("reset_req_ready", 32'(req_ready_v[s]), 32'd1);
      check_output("reset_resp_valid", 32'(resp_valid_v[s]), 32'd0);
      check_output("reset_rdata", rdata_v[s], 32'd0);
      check_output("reset_err", 32'(err_v[s]), 32'd0);
    end

    apply_stimulus(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'd0, 1'b0, 0);
    apply_stimulus(0, 1'b0, 32'h10, 4'h0, 32'd0, 32'hDEADBEEF, 1'b0, 0);

    apply_stimulus(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 32'd0, 1'b0, 0);
    apply_stimulus(0, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD, 32'd0, 1'b0, 0);
    apply_stimulus(0, 1'b0, 32'h20, 4'h0, 32'd0, 32'h11BB33DD, 1'b0, 5);

    apply_stimulus(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 32'd0, 1'b0, 0);
    apply_stimulus(0, 1'b0, 32'h6, 4'h0, 32'd0, 32'd0, 1'b1, 0);
    apply_stimulus(0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 32'd0, 1'b1, 0);
    apply_stimulus(0, 1'b0, 32'h0, 4'h0, 32'd0, 32'hCAFEF00D, 1'b0, 0);

    apply_stimulus(1, 1'b1, 32'h8, 4'hF, 32'h0BADF00D, 32'd0, 1'b0, 0);
    apply_stimulus(1, 1'b0, 32'h8, 4'h0, 32'd0, 32'h0BADF00D, 1'b0, 0);
    apply_stimulus(2, 1'b1, 32'h8, 4'hF, 32'h600DCAFE, 32'd0, 1'b0, 0);
    apply_stimulus(2, 1'b0, 32'h8, 4'h0, 32'd0, 32'h600DCAFE, 1'b0, 2);
    back_to_back(1);
    back_to_back(0);
    back_to_back(2);

    // Reset lands two edges after accept, one edge before the commit edge.
    apply_stimulus(3, 1'b1, 32'h40, 4'hF, 32'h12345678, 32'd0, 1'b0, 0);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h40; req_wstrb = 4'hF; req_wdata = 32'h55;
    req_valid_v[3] = 1'b1;
    check_output("rst_mid_accept_ready", 32'(req_ready_v[3]), 32'd1);
    @(posedge clk); #1;
    req_valid_v[3] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_output("rst_mid_idle", 32'(req_ready_v[3]), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check_output("rst_mid_no_resp", 32'(resp_valid_v[3]), 32'd0);
      @(negedge clk);
    end
    apply_stimulus(3, 1'b0, 32'h40, 4'h0, 32'd0, 32'h12345678, 1'b0, 0);

    check_output("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
